// File: rtl/display_scanner.sv
// Time-multiplexed seven-segment driver; steps one digit per rising edge of the divided tick_in wave.
// Optional leading-zero blanking is enabled by defining DISPLAY_BLANK_ZEROS_EN.
module display_scanner #(
    parameter int NDIGITS = 4,
    parameter int IDXW    = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   tick_in,
    input  logic                   enable,
    input  logic [4*NDIGITS-1:0]   valores,
    input  logic [NDIGITS-1:0]     puntos,
    output logic [NDIGITS-1:0]     anodos,
    output logic [6:0]             segmentos,
    output logic                   punto,
    output logic [IDXW-1:0]        digit_idx
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NDIGITS - 1);

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

`ifdef DISPLAY_BLANK_ZEROS_EN
    // Bit i set when nibble i and every nibble above it are zero; digit 0 always shown.
    function automatic logic [NDIGITS-1:0] lead_zero_mask(input logic [4*NDIGITS-1:0] v);
        logic [NDIGITS-1:0] m;
        logic               nz;
        m  = '0;
        nz = 1'b0;
        for (int i = NDIGITS - 1; i > 0; i--) begin
            nz   = nz | (v[4*i +: 4] != 4'h0);
            m[i] = ~nz;
        end
        return m;
    endfunction
`endif

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic                 edge_q, edge_d;
    logic                 first_q, first_d;
    logic                 armed_q, armed_d;
    logic                 step_q, step_d;
    logic                 shown_q, shown_d;
    logic [IDXW-1:0]      idx_q, idx_d;
    logic [4*NDIGITS-1:0] snap_val_q, snap_val_d;
    logic [NDIGITS-1:0]   snap_pt_q, snap_pt_d;
    logic [6:0]           seg_q, seg_d;
    logic                 dp_q, dp_d;
    logic [NDIGITS-1:0]   an_q, an_d;

    logic                 wrap;
    logic [IDXW-1:0]      idx_nxt;
    logic [4*NDIGITS-1:0] src_val;
    logic [NDIGITS-1:0]   src_pt;
    logic [3:0]           nib;
    logic                 blank;

    always_comb begin
        wrap    = (idx_q == LAST_IDX);
        idx_nxt = wrap ? '0 : idx_q + IDXW'(1);
        // The wrapping step displays the frame being captured, not the old snapshot.
        src_val = wrap ? valores : snap_val_q;
        src_pt  = wrap ? puntos  : snap_pt_q;
        nib     = src_val[4*idx_nxt +: 4];
`ifdef DISPLAY_BLANK_ZEROS_EN
        blank   = lead_zero_mask(src_val)[idx_nxt];
`else
        blank   = 1'b0;
`endif
    end

    always_comb begin
        sync1_d    = tick_in;
        sync2_d    = sync1_q;
        edge_d     = sync2_q;
        first_d    = 1'b1;
        // Only arm once tick_in has been seen low after reset, so a level already high at release makes no step.
        armed_d    = armed_q | (first_q & ~sync1_q);
        step_d     = armed_q & sync2_q & ~edge_q;
        shown_d    = shown_q;
        idx_d      = idx_q;
        snap_val_d = snap_val_q;
        snap_pt_d  = snap_pt_q;
        seg_d      = seg_q;
        dp_d       = dp_q;
        an_d       = an_q;

        if (!enable) begin
            an_d = '1;
        end else if (step_q) begin
            idx_d   = idx_nxt;
            seg_d   = blank ? 7'h7F : seg_decode(nib);
            dp_d    = ~src_pt[idx_nxt];
            an_d    = '1;
            shown_d = 1'b1;
            if (wrap) begin
                snap_val_d = valores;
                snap_pt_d  = puntos;
            end
        end else if (shown_q) begin
            an_d = ~(NDIGITS'(1) << idx_q);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            edge_q     <= 1'b0;
            first_q    <= 1'b0;
            armed_q    <= 1'b0;
            step_q     <= 1'b0;
            shown_q    <= 1'b0;
            idx_q      <= LAST_IDX;
            snap_val_q <= '0;
            snap_pt_q  <= '0;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            an_q       <= '1;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            edge_q     <= edge_d;
            first_q    <= first_d;
            armed_q    <= armed_d;
            step_q     <= step_d;
            shown_q    <= shown_d;
            idx_q      <= idx_d;
            snap_val_q <= snap_val_d;
            snap_pt_q  <= snap_pt_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign anodos    = an_q;
    assign segmentos = seg_q;
    assign punto     = dp_q;
    assign digit_idx = idx_q;

endmodule
